// File: rtl/dual_issue_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : dual_issue_scoreboard
// Purpose  : Per-register in-flight producer tracking for the dual-issue pipe.
// Revision : 1.0
// ============================================================================
module dual_issue_scoreboard #(
   parameter int NUM_REGS = 32,
   parameter int CNT_W    = 2
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                flush,
   input  logic                alloc0_valid,
   input  logic [4:0]          alloc0_rd,
   input  logic                alloc0_is_load,
   input  logic                alloc1_valid,
   input  logic [4:0]          alloc1_rd,
   input  logic                alloc1_is_load,
   input  logic                wb0_valid,
   input  logic [4:0]          wb0_rd,
   input  logic                wb1_valid,
   input  logic [4:0]          wb1_rd,
   input  logic                ld_done_valid,
   input  logic [4:0]          ld_done_rd,
   output logic [NUM_REGS-1:0] busy_vec,
   output logic [NUM_REGS-1:0] load_pending_vec,
   output logic                sb_empty,
   output logic                sb_err
);

   localparam logic [CNT_W-1:0] c_cnt_max = '1;

   logic [NUM_REGS-1:0] w_busy_next;
   logic [NUM_REGS-1:0] w_lp_next;
   logic [NUM_REGS-1:0] w_err_vec;

   for (genvar r = 0; r < NUM_REGS; r++) begin : g_reg
      if (r == 0) begin : g_x0
         assign w_busy_next[r] = 1'b0;
         assign w_lp_next[r]   = 1'b0;
         assign w_err_vec[r]   = 1'b0;
      end else begin : g_track
         logic [CNT_W-1:0]        r_count;
         logic [CNT_W-1:0]        w_cnt_next;
         logic                    w_a0_hit, w_a1_hit, w_wb0_hit, w_wb1_hit;
         logic [1:0]              w_inc, w_dec;
         logic signed [CNT_W+1:0] w_sum;
         logic                    w_set_lp, w_lp_hold, w_err;

         always_comb begin
            w_a0_hit   = alloc0_valid && (alloc0_rd == 5'(r));
            w_a1_hit   = alloc1_valid && (alloc1_rd == 5'(r));
            w_wb0_hit  = wb0_valid && (wb0_rd == 5'(r));
            w_wb1_hit  = wb1_valid && (wb1_rd == 5'(r));
            w_inc      = {1'b0, w_a0_hit} + {1'b0, w_a1_hit};
            w_dec      = {1'b0, w_wb0_hit} + {1'b0, w_wb1_hit};
            w_sum      = $signed({2'b00, r_count})
                       + $signed({{CNT_W{1'b0}}, w_inc})
                       - $signed({{CNT_W{1'b0}}, w_dec});
            w_cnt_next = w_sum[CNT_W-1:0];
            w_err      = 1'b0;
            // Sign bit flags underflow; bit CNT_W on a non-negative sum flags overflow.
            if (w_sum[CNT_W+1]) begin
               w_cnt_next = '0;
               w_err      = 1'b1;
            end else if (w_sum[CNT_W]) begin
               w_cnt_next = c_cnt_max;
               w_err      = 1'b1;
            end
            w_set_lp  = (w_a0_hit && alloc0_is_load) || (w_a1_hit && alloc1_is_load);
            w_lp_hold = load_pending_vec[r]
                      && !(ld_done_valid && (ld_done_rd == 5'(r)))
                      && (w_cnt_next != '0);
         end

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
               r_count <= '0;
            else if (flush)
               r_count <= '0;
            else
               r_count <= w_cnt_next;
         end

         assign w_busy_next[r] = !flush && (w_cnt_next != '0);
         assign w_lp_next[r]   = !flush && (w_set_lp || w_lp_hold);
         assign w_err_vec[r]   = !flush && w_err;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_vec         <= '0;
         load_pending_vec <= '0;
         sb_empty         <= 1'b1;
         sb_err           <= 1'b0;
      end else begin
         busy_vec         <= w_busy_next;
         load_pending_vec <= w_lp_next;
         sb_empty         <= ~|w_busy_next;
         sb_err           <= sb_err | (|w_err_vec);
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_dual_issue_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : tb_dual_issue_scoreboard
// Purpose  : Directed self-checking bench for dual_issue_scoreboard.
// Revision : 1.0
// ============================================================================
module tb_dual_issue_scoreboard;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        flush;
   logic        alloc0_valid, alloc0_is_load;
   logic [4:0]  alloc0_rd;
   logic        alloc1_valid, alloc1_is_load;
   logic [4:0]  alloc1_rd;
   logic        wb0_valid, wb1_valid, ld_done_valid;
   logic [4:0]  wb0_rd, wb1_rd, ld_done_rd;
   logic [31:0] busy_vec, load_pending_vec;
   logic        sb_empty, sb_err;

   int n_asserts = 0;
   int n_fail    = 0;

   dual_issue_scoreboard #(.NUM_REGS(32), .CNT_W(2)) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .flush            (flush),
      .alloc0_valid     (alloc0_valid),
      .alloc0_rd        (alloc0_rd),
      .alloc0_is_load   (alloc0_is_load),
      .alloc1_valid     (alloc1_valid),
      .alloc1_rd        (alloc1_rd),
      .alloc1_is_load   (alloc1_is_load),
      .wb0_valid        (wb0_valid),
      .wb0_rd           (wb0_rd),
      .wb1_valid        (wb1_valid),
      .wb1_rd           (wb1_rd),
      .ld_done_valid    (ld_done_valid),
      .ld_done_rd       (ld_done_rd),
      .busy_vec         (busy_vec),
      .load_pending_vec (load_pending_vec),
      .sb_empty         (sb_empty),
      .sb_err           (sb_err)
   );

   always #5 clk = ~clk;

   task automatic idle();
      flush = 1'b0;
      alloc0_valid = 1'b0; alloc0_rd = 5'd0; alloc0_is_load = 1'b0;
      alloc1_valid = 1'b0; alloc1_rd = 5'd0; alloc1_is_load = 1'b0;
      wb0_valid = 1'b0; wb0_rd = 5'd0;
      wb1_valid = 1'b0; wb1_rd = 5'd0;
      ld_done_valid = 1'b0; ld_done_rd = 5'd0;
   endtask

   // Apply the currently driven inputs for one edge, then return them to idle.
   task automatic step();
      @(posedge clk);
      #1;
      idle();
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_asserts++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      idle();
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      idle();
      rst_n = 1'b0;
      #12;
      check("rst_busy", busy_vec, 32'h0);
      check("rst_lp", load_pending_vec, 32'h0);
      check("rst_empty", {31'd0, sb_empty}, 32'd1);
      check("rst_err", {31'd0, sb_err}, 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      step();
      check("idle_busy", busy_vec, 32'h0);

      // Basic alloc / writeback
      alloc0_valid = 1'b1; alloc0_rd = 5'd5;
      step();
      check("a5_busy", busy_vec, 32'h0000_0020);
      check("a5_lp", load_pending_vec, 32'h0);
      check("a5_empty", {31'd0, sb_empty}, 32'd0);
      wb0_valid = 1'b1; wb0_rd = 5'd5;
      step();
      check("wb5_busy", busy_vec, 32'h0);
      check("wb5_empty", {31'd0, sb_empty}, 32'd1);

      // Load tracking on slot1
      alloc1_valid = 1'b1; alloc1_rd = 5'd7; alloc1_is_load = 1'b1;
      step();
      check("ld7_busy", busy_vec, 32'h0000_0080);
      check("ld7_lp", load_pending_vec, 32'h0000_0080);
      ld_done_valid = 1'b1; ld_done_rd = 5'd7;
      step();
      check("ldd7_busy", busy_vec, 32'h0000_0080);
      check("ldd7_lp", load_pending_vec, 32'h0);
      wb1_valid = 1'b1; wb1_rd = 5'd7;
      step();
      check("wb7_busy", busy_vec, 32'h0);

      // Two writers of one rd
      alloc0_valid = 1'b1; alloc0_rd = 5'd3;
      alloc1_valid = 1'b1; alloc1_rd = 5'd3;
      step();
      check("dual3_busy", busy_vec, 32'h0000_0008);
      wb0_valid = 1'b1; wb0_rd = 5'd3;
      step();
      check("dual3_wb1", busy_vec, 32'h0000_0008);
      wb1_valid = 1'b1; wb1_rd = 5'd3;
      step();
      check("dual3_wb2", busy_vec, 32'h0);
      check("dual3_empty", {31'd0, sb_empty}, 32'd1);

      // Simultaneous alloc/wb/ld_done on rd 9: count nets to 1, set wins
      alloc0_valid = 1'b1; alloc0_rd = 5'd9; alloc0_is_load = 1'b1;
      step();
      check("r9_lp0", load_pending_vec, 32'h0000_0200);
      alloc0_valid = 1'b1; alloc0_rd = 5'd9; alloc0_is_load = 1'b1;
      wb0_valid = 1'b1; wb0_rd = 5'd9;
      ld_done_valid = 1'b1; ld_done_rd = 5'd9;
      step();
      check("r9_busy", busy_vec, 32'h0000_0200);
      check("r9_lp", load_pending_vec, 32'h0000_0200);
      wb1_valid = 1'b1; wb1_rd = 5'd9;
      step();
      check("r9_drain_busy", busy_vec, 32'h0);
      check("r9_drain_lp", load_pending_vec, 32'h0);

      // x0 ignored, ld_done with nothing pending is harmless
      alloc0_valid = 1'b1; alloc0_rd = 5'd0; alloc0_is_load = 1'b1;
      ld_done_valid = 1'b1; ld_done_rd = 5'd10;
      wb0_valid = 1'b1; wb0_rd = 5'd0;
      step();
      check("x0_busy", busy_vec, 32'h0);
      check("x0_lp", load_pending_vec, 32'h0);
      check("x0_err", {31'd0, sb_err}, 32'd0);

      // Underflow sets sticky error that survives flush
      wb1_valid = 1'b1; wb1_rd = 5'd12;
      step();
      check("uf_err", {31'd0, sb_err}, 32'd1);
      check("uf_busy", busy_vec, 32'h0);
      flush = 1'b1;
      step();
      check("uf_err_flush", {31'd0, sb_err}, 32'd1);

      // Saturation at 3 after a clean reset
      do_reset();
      check("sat_err_rst", {31'd0, sb_err}, 32'd0);
      alloc0_valid = 1'b1; alloc0_rd = 5'd4;
      alloc1_valid = 1'b1; alloc1_rd = 5'd4;
      step();
      check("sat_err_c2", {31'd0, sb_err}, 32'd0);
      alloc0_valid = 1'b1; alloc0_rd = 5'd4;
      alloc1_valid = 1'b1; alloc1_rd = 5'd4;
      step();
      check("sat_err", {31'd0, sb_err}, 32'd1);
      check("sat_busy", busy_vec, 32'h0000_0010);
      wb0_valid = 1'b1; wb0_rd = 5'd4;
      wb1_valid = 1'b1; wb1_rd = 5'd4;
      step();
      check("sat_cnt1", busy_vec, 32'h0000_0010);
      wb0_valid = 1'b1; wb0_rd = 5'd4;
      step();
      check("sat_cnt0", busy_vec, 32'h0);

      // Flush drops same-cycle allocation
      alloc0_valid = 1'b1; alloc0_rd = 5'd1;
      alloc1_valid = 1'b1; alloc1_rd = 5'd2; alloc1_is_load = 1'b1;
      step();
      alloc0_valid = 1'b1; alloc0_rd = 5'd3;
      step();
      check("pre_flush_busy", busy_vec, 32'h0000_000E);
      check("pre_flush_lp", load_pending_vec, 32'h0000_0004);
      flush = 1'b1;
      alloc0_valid = 1'b1; alloc0_rd = 5'd6; alloc0_is_load = 1'b1;
      step();
      check("flush_busy", busy_vec, 32'h0);
      check("flush_lp", load_pending_vec, 32'h0);
      check("flush_empty", {31'd0, sb_empty}, 32'd1);
      check("flush_err", {31'd0, sb_err}, 32'd1);
      step();
      check("flush_after", busy_vec, 32'h0);

      // Asynchronous reset between edges
      alloc0_valid = 1'b1; alloc0_rd = 5'd5; alloc0_is_load = 1'b1;
      step();
      check("ar_pre_busy", busy_vec, 32'h0000_0020);
      #2;
      rst_n = 1'b0;
      #1;
      check("ar_busy", busy_vec, 32'h0);
      check("ar_lp", load_pending_vec, 32'h0);
      check("ar_empty", {31'd0, sb_empty}, 32'd1);
      check("ar_err", {31'd0, sb_err}, 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      step();
      check("ar_post", busy_vec, 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
